fft_wb_agu: RTL and testbench
=============================

FFT_WB_AGU -- requirements
Module: fft_wb_agu

Interface
REQ-001 Parameter N_LOG2, default 10: log2 of FFT length; N = 2**N_LOG2.
REQ-002 Parameter LAT, default 5: BFU pipeline latency in cycles, legal range 1..16.
REQ-003 Parameter CW, default 32: complex word width, {r[15:0], i[15:0]}, 1 sign + 15 fraction bits each.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin new FFT; clears counters.
REQ-007 in_valid  in  1  AGU issued a butterfly this cycle.
REQ-008 rd_addrA  in  N_LOG2  AGU address of butterfly input A.
REQ-009 rd_addrB  in  N_LOG2  AGU address of butterfly input B.
REQ-010 bank_sel  in  1  0: read RAM A / write RAM B; 1: read RAM B / write RAM A.
REQ-011 stage  in  N_LOG2  AGU stage index for the issued butterfly.
REQ-012 bfu_outA  in  CW  BFU result A, valid LAT cycles after the matching in_valid.
REQ-013 bfu_outB  in  CW  BFU result B, same timing as bfu_outA.
REQ-014 wa_we  out  1  write enable for both ports of RAM A.
REQ-015 wa_addra / wa_addrb  out  N_LOG2 each  RAM A port A / port B write addresses.
REQ-016 wa_dina / wa_dinb  out  CW each  RAM A port A / port B write data.
REQ-017 wb_we, wb_addra, wb_addrb, wb_dina, wb_dinb  out  1 / N_LOG2 / N_LOG2 / CW / CW  RAM B equivalents of REQ-014..016.
REQ-018 inflight  out  5  butterflies issued but not yet written.
REQ-019 stage_wr_done  out  1  one-cycle pulse: last butterfly of a stage written.
REQ-020 fft_wr_done  out  1  one-cycle pulse: last butterfly of the final stage written.
REQ-021 err_ovf  out  1  sticky: stage counter exceeded N/2 or stage tag mismatch.

Function
REQ-022 Internal delay line of depth LAT carries {valid, addrA, addrB, bank_sel, stage} per entry and advances every cycle; no stall exists.
REQ-023 Tap entry at depth LAT (the "retire" entry) drives write ports combinationally from registered state plus the bfu_out inputs.
REQ-024 Retire valid with bank_sel=0: wb_we=1, wb_addra=addrA, wb_addrb=addrB, wb_dina=bfu_outA, wb_dinb=bfu_outB; wa_we=0.
REQ-025 Retire valid with bank_sel=1: mirror of REQ-024 onto the wa_* port; wb_we=0.
REQ-026 Retire entry not valid: wa_we=wb_we=0; address and data outputs are don't-care but SHALL be driven 0.
REQ-027 Write latency: in_valid at cycle t produces a write strobe in cycle t+LAT exactly.
REQ-028 inflight: +1 on in_valid, -1 on retire; both in the same cycle leave it unchanged; range 0..LAT.
REQ-029 Butterfly counter bf_cnt (N_LOG2 bits) increments on each retire; on reaching N/2 it wraps to 0 and stage_wr_done pulses in the cycle after the final write.
REQ-030 Expected stage counter exp_stage increments on each stage_wr_done; fft_wr_done pulses alongside stage_wr_done when exp_stage = N_LOG2-1, after which exp_stage returns to 0.
REQ-031 A retire whose stage tag differs from exp_stage sets err_ovf; the write still proceeds.
REQ-032 start clears bf_cnt and exp_stage only; entries already in the delay line still retire and write normally.
REQ-033 Simultaneous start and retire: the retire is counted against the cleared state (bf_cnt becomes 1).
REQ-034 err_ovf is cleared only by rst.

Reset
REQ-035 While rst is high: delay line valids=0, inflight=0, bf_cnt=0, exp_stage=0, err_ovf=0, all *_we=0, pulses=0, all address and data outputs 0.
REQ-036 rst asserted mid-operation discards in-flight butterflies; no write strobe is issued for them after rst is released.

Verification
REQ-037 Single in_valid at t=10, A=3, B=515, bank_sel=0, bfu_outA=32'h1234_5678 at t=15 -> wb_we=1 at t=15 only, wb_addra=3, wb_addrb=515, wb_dina=32'h1234_5678; wa_we=0 throughout.
REQ-038 512 back-to-back in_valid pulses, stage=0, bank_sel=1 -> 512 consecutive wa_we cycles, inflight reaches 5, one stage_wr_done one cycle after the last write, err_ovf=0.
REQ-039 Full 10-stage FFT with bank_sel alternating per stage -> 10 stage_wr_done pulses, exactly one fft_wr_done coincident with the 10th, inflight=0 at the end.
REQ-040 Retire tagged stage=2 while exp_stage=1 -> err_ovf=1 and remains 1 until rst; the write still occurs.
REQ-041 rst asserted with inflight=3 -> all outputs 0 asynchronously; no *_we pulse in the 5 cycles after rst is released.
REQ-042 start asserted in the same cycle as a retire, with bf_cnt=200 -> bf_cnt=1 next cycle, exp_stage=0.

Source files
------------

// File: rtl/fft_wb_agu.sv
// Write-back address generator for an in-place radix-2 FFT.
// Butterfly addresses issued by the AGU are delayed by the BFU latency and
// paired with the BFU results to drive the ping-pong RAM write ports.
// Retired butterflies are counted per stage, and stage tags are checked.
module fft_wb_agu #(
  parameter int N_LOG2 = 10,
  parameter int LAT    = 5,
  parameter int CW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [N_LOG2-1:0] rd_addrA,
  input  logic [N_LOG2-1:0] rd_addrB,
  input  logic              bank_sel,
  input  logic [N_LOG2-1:0] stage,
  input  logic [CW-1:0]     bfu_outA,
  input  logic [CW-1:0]     bfu_outB,
  output logic              wa_we,
  output logic [N_LOG2-1:0] wa_addra,
  output logic [N_LOG2-1:0] wa_addrb,
  output logic [CW-1:0]     wa_dina,
  output logic [CW-1:0]     wa_dinb,
  output logic              wb_we,
  output logic [N_LOG2-1:0] wb_addra,
  output logic [N_LOG2-1:0] wb_addrb,
  output logic [CW-1:0]     wb_dina,
  output logic [CW-1:0]     wb_dinb,
  output logic [4:0]        inflight,
  output logic              stage_wr_done,
  output logic              fft_wr_done,
  output logic              err_ovf
);

  // Last butterfly index of a stage (N/2 - 1) and index of the final stage.
  localparam logic [N_LOG2-1:0] LAST_BF    = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [N_LOG2-1:0] LAST_STAGE = N_LOG2'(N_LOG2 - 1);

  logic [LAT-1:0]    vld_q;
  logic [N_LOG2-1:0] addra_q [LAT];
  logic [N_LOG2-1:0] addrb_q [LAT];
  logic [N_LOG2-1:0] stage_q [LAT];
  logic              bank_q  [LAT];

  logic              retire;
  logic              r_bank;
  logic [N_LOG2-1:0] r_addra, r_addrb, r_stage;

  logic [N_LOG2-1:0] bf_cnt_q, bf_cnt_d, exp_stage_q, exp_stage_d;
  logic [N_LOG2-1:0] bf_base, exp_base;
  logic [4:0]        inflight_q, inflight_d;
  logic              stage_done_q, stage_done_d;
  logic              fft_done_q, fft_done_d;
  logic              err_q, err_d;

  // Valid bits of the delay line; cleared by reset so in-flight work is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload of the delay line; qualified by vld_q, so no reset is needed.
  always_ff @(posedge clk) begin
    addra_q[0] <= rd_addrA;
    addrb_q[0] <= rd_addrB;
    stage_q[0] <= stage;
    bank_q[0]  <= bank_sel;
    for (int i = 1; i < LAT; i++) begin
      addra_q[i] <= addra_q[i-1];
      addrb_q[i] <= addrb_q[i-1];
      stage_q[i] <= stage_q[i-1];
      bank_q[i]  <= bank_q[i-1];
    end
  end

  assign retire  = vld_q[LAT-1];
  assign r_bank  = bank_q[LAT-1];
  assign r_addra = addra_q[LAT-1];
  assign r_addrb = addrb_q[LAT-1];
  assign r_stage = stage_q[LAT-1];

  // Steer the retiring butterfly to the RAM not being read; idle ports drive 0.
  always_comb begin
    wa_we    = 1'b0;
    wa_addra = '0;
    wa_addrb = '0;
    wa_dina  = '0;
    wa_dinb  = '0;
    wb_we    = 1'b0;
    wb_addra = '0;
    wb_addrb = '0;
    wb_dina  = '0;
    wb_dinb  = '0;
    if (retire) begin
      if (r_bank) begin
        wa_we    = 1'b1;
        wa_addra = r_addra;
        wa_addrb = r_addrb;
        wa_dina  = bfu_outA;
        wa_dinb  = bfu_outB;
      end else begin
        wb_we    = 1'b1;
        wb_addra = r_addra;
        wb_addrb = r_addrb;
        wb_dina  = bfu_outA;
        wb_dinb  = bfu_outB;
      end
    end
  end

  // Next-state for counters; start clears first so a same-cycle retire counts from zero.
  always_comb begin
    bf_base      = start ? '0 : bf_cnt_q;
    exp_base     = start ? '0 : exp_stage_q;
    bf_cnt_d     = bf_base;
    exp_stage_d  = exp_base;
    stage_done_d = 1'b0;
    fft_done_d   = 1'b0;
    err_d        = err_q;
    inflight_d   = inflight_q + {4'b0, in_valid} - {4'b0, retire};
    if (retire) begin
      if (r_stage != exp_base) err_d = 1'b1;
      if (bf_base == LAST_BF) begin
        bf_cnt_d     = '0;
        stage_done_d = 1'b1;
        if (exp_base == LAST_STAGE) begin
          fft_done_d  = 1'b1;
          exp_stage_d = '0;
        end else begin
          exp_stage_d = exp_base + 1'b1;
        end
      end else begin
        bf_cnt_d = bf_base + 1'b1;
      end
    end
  end

  // Counter, pulse and sticky-error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bf_cnt_q     <= '0;
      exp_stage_q  <= '0;
      inflight_q   <= '0;
      stage_done_q <= 1'b0;
      fft_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bf_cnt_q     <= bf_cnt_d;
      exp_stage_q  <= exp_stage_d;
      inflight_q   <= inflight_d;
      stage_done_q <= stage_done_d;
      fft_done_q   <= fft_done_d;
      err_q        <= err_d;
    end
  end

  assign inflight      = inflight_q;
  assign stage_wr_done = stage_done_q;
  assign fft_wr_done   = fft_done_q;
  assign err_ovf       = err_q;

endmodule

// File: tb/tb_fft_wb_agu.sv
// Directed bench for fft_wb_agu (N_LOG2=10, LAT=5).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fft_wb_agu;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, bank_sel;
  logic [9:0]  rd_addrA, rd_addrB, stage;
  logic [31:0] bfu_outA, bfu_outB;
  logic        wa_we, wb_we;
  logic [9:0]  wa_addra, wa_addrb, wb_addra, wb_addrb;
  logic [31:0] wa_dina, wa_dinb, wb_dina, wb_dinb;
  logic [4:0]  inflight;
  logic        stage_wr_done, fft_wr_done, err_ovf;

  int n_cmp = 0;
  int n_err = 0;

  fft_wb_agu #(.N_LOG2(10), .LAT(5), .CW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .bank_sel(bank_sel), .stage(stage),
    .bfu_outA(bfu_outA), .bfu_outB(bfu_outB),
    .wa_we(wa_we), .wa_addra(wa_addra), .wa_addrb(wa_addrb), .wa_dina(wa_dina), .wa_dinb(wa_dinb),
    .wb_we(wb_we), .wb_addra(wb_addra), .wb_addrb(wb_addrb), .wb_dina(wb_dina), .wb_dinb(wb_dinb),
    .inflight(inflight), .stage_wr_done(stage_wr_done), .fft_wr_done(fft_wr_done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    start = 1'b0; in_valid = 1'b0; bank_sel = 1'b0;
    rd_addrA = '0; rd_addrB = '0; stage = '0;
    bfu_outA = '0; bfu_outB = '0;
  endtask

  int errs, we_cnt, max_inf, sd_cnt, sd_k, fft_cnt, j, sj;
  logic exp_we, exp_sd, exp_wa, exp_wb;

  initial begin
    idle();
    rst = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_wa_we", 64'(wa_we), 64'(0));
    chk("rst_wb_we", 64'(wb_we), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_pulses", 64'({stage_wr_done, fft_wr_done, err_ovf}), 64'(0));
    chk("rst_addr", 64'({wa_addra, wb_addrb}), 64'(0));
    @(negedge clk); rst = 1'b0;

    // Single butterfly into RAM B, exact latency
    we_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      idle();
      in_valid = (k == 0); rd_addrA = 10'd3; rd_addrB = 10'd515; bank_sel = 1'b0;
      bfu_outA = (k == 5) ? 32'h1234_5678 : 32'hDEAD_0000 + 32'(k);
      bfu_outB = (k == 5) ? 32'h0BAD_F00D : 32'hBEEF_0000 + 32'(k);
      #1;
      chk("t1_wb_we", 64'(wb_we), 64'(k == 5));
      if (wa_we) we_cnt++;
      if (k == 3) chk("t1_inflight_mid", 64'(inflight), 64'(1));
      if (k == 5) begin
        chk("t1_addra", 64'(wb_addra), 64'(3));
        chk("t1_addrb", 64'(wb_addrb), 64'(515));
        chk("t1_dina", 64'(wb_dina), 64'h1234_5678);
        chk("t1_dinb", 64'(wb_dinb), 64'h0BAD_F00D);
      end
      if (k == 6) begin
        chk("t1_inflight_end", 64'(inflight), 64'(0));
        chk("t1_idle_zero", 64'({wb_addra, wb_dina}), 64'(0));
      end
    end
    chk("t1_wa_we_never", 64'(we_cnt), 64'(0));

    // One full stage back-to-back into RAM A
    @(negedge clk); idle(); start = 1'b1;
    errs = 0; we_cnt = 0; max_inf = 0; sd_cnt = 0; sd_k = -1; fft_cnt = 0;
    for (int k = 0; k < 525; k++) begin
      @(negedge clk);
      idle();
      in_valid = (k < 512); rd_addrA = 10'(k); rd_addrB = 10'(k + 512);
      bank_sel = 1'b1; stage = '0;
      bfu_outA = {16'(k), 16'h5A5A}; bfu_outB = ~{16'(k), 16'h5A5A};
      #1;
      exp_we = (k >= 5) && (k < 517);
      if (wa_we !== exp_we || wb_we !== 1'b0) errs++;
      if (exp_we && (wa_addra !== 10'(k - 5) || wa_addrb !== 10'(k - 5 + 512)
                     || wa_dina !== bfu_outA || wa_dinb !== bfu_outB)) errs++;
      if (wa_we) we_cnt++;
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
      if (stage_wr_done) begin sd_cnt++; sd_k = k; end
      if (fft_wr_done) fft_cnt++;
    end
    chk("t2_port_errs", 64'(errs), 64'(0));
    chk("t2_we_cnt", 64'(we_cnt), 64'(512));
    chk("t2_max_inflight", 64'(max_inf), 64'(5));
    chk("t2_sdone_cnt", 64'(sd_cnt), 64'(1));
    chk("t2_sdone_cycle", 64'(sd_k), 64'(517));
    chk("t2_fft_cnt", 64'(fft_cnt), 64'(0));
    chk("t2_err_ovf", 64'(err_ovf), 64'(0));

    // Stage tag 2 while stage 1 is expected
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      idle();
      in_valid = (k == 0); rd_addrA = 10'd7; rd_addrB = 10'd8; stage = 10'd2;
      bfu_outA = 32'hCAFE_0001;
      #1;
      if (k == 4) chk("t3_err_before", 64'(err_ovf), 64'(0));
      if (k == 5) begin
        chk("t3_write_happens", 64'(wb_we), 64'(1));
        chk("t3_write_addr", 64'(wb_addra), 64'(7));
      end
      if (k == 6) chk("t3_err_set", 64'(err_ovf), 64'(1));
    end
    @(negedge clk); idle(); start = 1'b1;
    @(negedge clk); idle(); #1;
    chk("t3_err_sticky", 64'(err_ovf), 64'(1));

    // Asynchronous reset with three butterflies in flight
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      in_valid = (k < 3); rd_addrA = 10'(k); bank_sel = 1'b0;
      bfu_outA = 32'hFFFF_FFFF; bfu_outB = 32'hFFFF_FFFF;
      #1;
    end
    chk("t4_inflight_pre", 64'(inflight), 64'(3));
    #2 rst = 1'b1;
    #1;
    chk("t4_async_inflight", 64'(inflight), 64'(0));
    chk("t4_async_err", 64'(err_ovf), 64'(0));
    chk("t4_async_we", 64'({wa_we, wb_we, stage_wr_done, fft_wr_done}), 64'(0));
    chk("t4_async_data", 64'({wb_addra, wb_dina}), 64'(0));
    @(negedge clk); rst = 1'b0;
    we_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (wa_we || wb_we) we_cnt++;
    end
    chk("t4_no_we_after", 64'(we_cnt), 64'(0));

    // Full 10-stage FFT, bank alternating per stage
    errs = 0; sd_cnt = 0; fft_cnt = 0;
    for (int k = 0; k < 5131; k++) begin
      @(negedge clk);
      idle();
      in_valid = (k < 5120);
      if (k < 5120) begin
        stage = 10'(k / 512); bank_sel = stage[0];
        rd_addrA = 10'(k % 512); rd_addrB = 10'(k % 512) ^ 10'h200;
      end
      bfu_outA = 32'(k);
      #1;
      j = k - 5;
      exp_wa = 1'b0; exp_wb = 1'b0;
      if (j >= 0 && j < 5120) begin
        sj = j / 512;
        exp_wa = (sj % 2) == 1;
        exp_wb = (sj % 2) == 0;
      end
      if (wa_we !== exp_wa || wb_we !== exp_wb) errs++;
      exp_sd = (j >= 512) && (j <= 5120) && (j % 512 == 0);
      if (stage_wr_done !== exp_sd) errs++;
      if (fft_wr_done !== (k == 5125)) errs++;
      if (stage_wr_done) sd_cnt++;
      if (fft_wr_done) begin
        fft_cnt++;
        chk("t5_fft_with_sdone", 64'(stage_wr_done), 64'(1));
        chk("t5_fft_is_10th", 64'(sd_cnt), 64'(10));
      end
    end
    chk("t5_timing_errs", 64'(errs), 64'(0));
    chk("t5_sdone_cnt", 64'(sd_cnt), 64'(10));
    chk("t5_fft_cnt", 64'(fft_cnt), 64'(1));
    chk("t5_err_ovf", 64'(err_ovf), 64'(0));
    chk("t5_inflight_end", 64'(inflight), 64'(0));

    // start coinciding with a retire while 200 butterflies are counted
    for (int k = 0; k < 206; k++) begin
      @(negedge clk);
      idle();
      in_valid = (k < 200);
    end
    sd_cnt = 0; sd_k = -1; fft_cnt = 0;
    for (int k = 0; k < 526; k++) begin
      @(negedge clk);
      idle();
      in_valid = (k < 512); start = (k == 5); rd_addrA = 10'(k);
      #1;
      if (k == 5) chk("t6_retire_at_start", 64'(wb_we), 64'(1));
      if (k == 6) begin
        chk("t6_bf_cnt", 64'(dut.bf_cnt_q), 64'(1));
        chk("t6_exp_stage", 64'(dut.exp_stage_q), 64'(0));
      end
      if (stage_wr_done) begin sd_cnt++; sd_k = k; end
      if (fft_wr_done) fft_cnt++;
    end
    chk("t6_sdone_cnt", 64'(sd_cnt), 64'(1));
    chk("t6_sdone_cycle", 64'(sd_k), 64'(517));
    chk("t6_fft_cnt", 64'(fft_cnt), 64'(0));
    chk("t6_err_ovf", 64'(err_ovf), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
